// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video scanout has priority, and the CPU gets a bounded-wait grant.
// One access is issued per cycle, and read data returns to its owner in grant order.
module vram_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]    starve_cnt_q, starve_cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic [RD_LAT:0] vld_pipe_q, vld_pipe_d;
    logic [RD_LAT:0] own_pipe_q, own_pipe_d;   // 1 = CPU owns the read in this slot
    logic [DW-1:0] vid_rdata_q, vid_rdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          vid_rvalid_q, vid_rvalid_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          cpu_win;
    logic          rd_issue;

    always_comb begin
        cpu_win = cpu_req && (!vid_req || (starve_cnt_q == STARVE_LIM));
        vid_ack = !RESET && vid_req && !cpu_win;
        cpu_ack = !RESET && cpu_req && cpu_win;

        starve_cnt_d = 8'd0;
        if (cpu_req && !cpu_ack)
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 8'd1;

        // Video carries no write data, so mem_wdata only moves on CPU grants.
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (vid_ack) begin
            mem_addr_d = vid_addr;
        end else if (cpu_ack) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_we_d    = cpu_we;
        end

        rd_issue   = vid_ack || (cpu_ack && !cpu_we);
        vld_pipe_d = {vld_pipe_q[RD_LAT-1:0], rd_issue};
        own_pipe_d = {own_pipe_q[RD_LAT-1:0], cpu_ack};

        vid_rvalid_d = vld_pipe_q[RD_LAT] && !own_pipe_q[RD_LAT];
        cpu_rvalid_d = vld_pipe_q[RD_LAT] &&  own_pipe_q[RD_LAT];
        vid_rdata_d  = vid_rvalid_d ? mem_rdata : vid_rdata_q;
        cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            starve_cnt_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            vld_pipe_q   <= '0;
            own_pipe_q   <= '0;
            vid_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            vld_pipe_q   <= vld_pipe_d;
            own_pipe_q   <= own_pipe_d;
            vid_rdata_q  <= vid_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign vid_rdata  = vid_rdata_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: three instances (RD_LAT 2, 1, 4) share one stimulus stream.
// Each instance is checked every cycle against a grant/return model, and literal expectations pin that model.
module tb_vram_arbiter;

    localparam int NI     = 3;
    localparam int STARVE = 8;
    localparam int NOBS   = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vid_req, cpu_req, cpu_we;
    logic [15:0] vid_addr, cpu_addr;
    logic [7:0]  cpu_wdata;

    logic [NI-1:0]       vid_ack_w, vid_rvalid_w, cpu_ack_w, cpu_rvalid_w, mem_we_w;
    logic [NI-1:0][7:0]  vid_rdata_w, cpu_rdata_w, mem_wdata_w, mem_rdata_w;
    logic [NI-1:0][15:0] mem_addr_w;

    function automatic logic [7:0] init_val(int a);
        if (a == 16) return 8'hA0;
        if (a == 17) return 8'hA1;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic int lat_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_i
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        logic [7:0] ram [int];
        logic [7:0] chain [4];

        vram_arbiter #(.AW(16), .DW(8), .RD_LAT(L), .STARVE_MAX(STARVE)) dut (
            .CLOCK(clk), .RESET(rst),
            .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack_w[g]),
            .vid_rdata(vid_rdata_w[g]), .vid_rvalid(vid_rvalid_w[g]),
            .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
            .cpu_ack(cpu_ack_w[g]), .cpu_rdata(cpu_rdata_w[g]), .cpu_rvalid(cpu_rvalid_w[g]),
            .mem_addr(mem_addr_w[g]), .mem_we(mem_we_w[g]), .mem_wdata(mem_wdata_w[g]),
            .mem_rdata(mem_rdata_w[g])
        );

        // Synchronous RAM: data for the address presented in cycle n appears in cycle n+L.
        always @(posedge clk) begin
            if (mem_we_w[g]) ram[int'(mem_addr_w[g])] = mem_wdata_w[g];
            chain[0] <= ram.exists(int'(mem_addr_w[g])) ? ram[int'(mem_addr_w[g])]
                                                       : init_val(int'(mem_addr_w[g]));
            for (int k = 1; k < 4; k++) chain[k] <= chain[k-1];
        end
        assign mem_rdata_w[g] = chain[L-1];
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model state, one copy per instance.
    int         cnt [NI];
    int         qh [NI], qt [NI];
    int         qdue [NI][16];
    bit         qcpu [NI][16];
    logic [7:0] qdat [NI][16];
    logic [7:0] last_v [NI], last_c [NI];
    logic [15:0] exp_ma [NI];
    logic [7:0] exp_mwd [NI];
    bit         exp_mwe [NI];
    logic [7:0] refmem [int];
    bit         m_vg, m_cg;

    // Instance 0 observations, used by the literal checks.
    bit         obs_vack [NOBS], obs_cack [NOBS], obs_vrv [NOBS], obs_crv [NOBS], obs_mwe [NOBS];
    logic [7:0] obs_vrd [NOBS], obs_crd [NOBS], obs_mwd [NOBS];
    logic [15:0] obs_ma [NOBS];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] ref_rd(int i, logic [15:0] a);
        int key = (i << 16) | int'(a);
        return refmem.exists(key) ? refmem[key] : init_val(int'(a));
    endfunction

    task automatic model_cycle(int i);
        bit cw, ev, ec, erv_v, erv_c;
        int idx;
        string p = $sformatf("c%0d i%0d", cyc, i);
        if (rst) begin
            chk({p, " vid_ack(rst)"}, 32'(vid_ack_w[i]), 0);
            chk({p, " cpu_ack(rst)"}, 32'(cpu_ack_w[i]), 0);
            cnt[i] = 0; qh[i] = qt[i]; last_v[i] = 8'h00; last_c[i] = 8'h00;
            exp_ma[i] = 16'h0000; exp_mwd[i] = 8'h00; exp_mwe[i] = 1'b0;
            if (i == 0) begin m_vg = 1'b0; m_cg = 1'b0; end
            return;
        end
        cw = cpu_req && (!vid_req || cnt[i] == STARVE);
        ev = vid_req && !cw;
        ec = cpu_req && cw;
        chk({p, " vid_ack"}, 32'(vid_ack_w[i]), 32'(ev));
        chk({p, " cpu_ack"}, 32'(cpu_ack_w[i]), 32'(ec));
        chk({p, " mem_we"}, 32'(mem_we_w[i]), 32'(exp_mwe[i]));
        chk({p, " mem_addr"}, 32'(mem_addr_w[i]), 32'(exp_ma[i]));
        if (exp_mwe[i]) chk({p, " mem_wdata"}, 32'(mem_wdata_w[i]), 32'(exp_mwd[i]));
        erv_v = 1'b0; erv_c = 1'b0;
        if (qh[i] != qt[i] && qdue[i][qh[i] % 16] == cyc) begin
            idx = qh[i] % 16;
            if (qcpu[i][idx]) begin erv_c = 1'b1; last_c[i] = qdat[i][idx]; end
            else              begin erv_v = 1'b1; last_v[i] = qdat[i][idx]; end
            qh[i]++;
        end
        chk({p, " vid_rvalid"}, 32'(vid_rvalid_w[i]), 32'(erv_v));
        chk({p, " cpu_rvalid"}, 32'(cpu_rvalid_w[i]), 32'(erv_c));
        chk({p, " vid_rdata"}, 32'(vid_rdata_w[i]), 32'(last_v[i]));
        chk({p, " cpu_rdata"}, 32'(cpu_rdata_w[i]), 32'(last_c[i]));
        // Apply this cycle's grant to the model.
        exp_mwe[i] = 1'b0;
        if (ev || (ec && !cpu_we)) begin
            idx = qt[i] % 16;
            qcpu[i][idx] = ec;
            qdat[i][idx] = ref_rd(i, ev ? vid_addr : cpu_addr);
            qdue[i][idx] = cyc + 2 + lat_of(i);
            qt[i]++;
        end
        if (ev) exp_ma[i] = vid_addr;
        if (ec) begin
            exp_ma[i] = cpu_addr;
            if (cpu_we) begin
                exp_mwe[i] = 1'b1;
                exp_mwd[i] = cpu_wdata;
                refmem[(i << 16) | int'(cpu_addr)] = cpu_wdata;
            end
        end
        cnt[i] = (cpu_req && !ec) ? ((cnt[i] < STARVE) ? cnt[i] + 1 : STARVE) : 0;
        if (i == 0) begin m_vg = ev; m_cg = ec; end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) model_cycle(i);
        if (cyc < NOBS) begin
            obs_vack[cyc] = vid_ack_w[0];   obs_cack[cyc] = cpu_ack_w[0];
            obs_vrv[cyc]  = vid_rvalid_w[0]; obs_crv[cyc] = cpu_rvalid_w[0];
            obs_vrd[cyc]  = vid_rdata_w[0];  obs_crd[cyc] = cpu_rdata_w[0];
            obs_mwe[cyc]  = mem_we_w[0];     obs_ma[cyc]  = mem_addr_w[0];
            obs_mwd[cyc]  = mem_wdata_w[0];
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(int n);
        vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int t0, s, vn, cn;
        rst = 1'b1; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        vid_addr = 16'h0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        tick(); tick();
        rst = 1'b0;
        idle(2);

        // Lone video, back-to-back reads of preloaded 0x10/0x11.
        t0 = cyc;
        vid_req = 1'b1; vid_addr = 16'h0010; tick();
        vid_addr = 16'h0011; tick();
        idle(8);
        chk("t1 vack t", 32'(obs_vack[t0]), 1);
        chk("t1 vack t+1", 32'(obs_vack[t0+1]), 1);
        chk("t1 vrv t+3", 32'(obs_vrv[t0+3]), 0);
        chk("t1 vrv t+4", 32'(obs_vrv[t0+4]), 1);
        chk("t1 vrd t+4", 32'(obs_vrd[t0+4]), 32'hA0);
        chk("t1 vrv t+5", 32'(obs_vrv[t0+5]), 1);
        chk("t1 vrd t+5", 32'(obs_vrd[t0+5]), 32'hA1);

        // CPU write then read of the same address.
        t0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A; tick();
        cpu_we = 1'b0; tick();
        idle(8);
        chk("t2 mem_we t+1", 32'(obs_mwe[t0+1]), 1);
        chk("t2 mem_wdata t+1", 32'(obs_mwd[t0+1]), 32'h5A);
        chk("t2 mem_we t+2", 32'(obs_mwe[t0+2]), 0);
        chk("t2 crv t+5", 32'(obs_crv[t0+5]), 1);
        chk("t2 crd t+5", 32'(obs_crd[t0+5]), 32'h5A);
        s = 0;
        for (int k = t0; k < t0 + 10; k++) s += int'(obs_vrv[k]) + int'(obs_crv[k]);
        chk("t2 rvalid count", 32'(s), 1);

        // Both requesting continuously: starvation bound forces a CPU grant every 9th cycle.
        t0 = cyc;
        vid_req = 1'b1; vid_addr = 16'h0040; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0041;
        for (int k = 0; k < 19; k++) tick();
        idle(8);
        chk("t3 vack 7", 32'(obs_vack[t0+7]), 1);
        chk("t3 cack 8", 32'(obs_cack[t0+8]), 1);
        chk("t3 vack 8", 32'(obs_vack[t0+8]), 0);
        chk("t3 cack 17", 32'(obs_cack[t0+17]), 1);
        s = 0;
        for (int k = t0; k < t0 + 18; k++) s += int'(obs_cack[k]);
        chk("t3 cack count", 32'(s), 2);

        // Lone CPU granted immediately, then video reads the freshly written byte.
        t0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h77; tick();
        cpu_req = 1'b0; cpu_we = 1'b0; vid_req = 1'b1; vid_addr = 16'h0300; tick();
        idle(8);
        chk("t4 cack t", 32'(obs_cack[t0]), 1);
        chk("t4 vack t", 32'(obs_vack[t0]), 0);
        chk("t4 vack t+1", 32'(obs_vack[t0+1]), 1);
        chk("t4 vrd t+5", 32'(obs_vrd[t0+5]), 32'h77);

        // Reset while two video reads are in flight.
        t0 = cyc;
        vid_req = 1'b1; vid_addr = 16'h0010; tick();
        vid_addr = 16'h0011; tick();
        vid_req = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        idle(8);
        s = 0;
        for (int k = t0 + 2; k < t0 + 10; k++) s += int'(obs_vrv[k]);
        chk("t5 vrv after rst", 32'(s), 0);
        chk("t5 mem_addr", 32'(obs_ma[t0+3]), 0);
        chk("t5 mem_wdata", 32'(obs_mwd[t0+3]), 0);
        chk("t5 vid_rdata", 32'(obs_vrd[t0+3]), 0);
        chk("t5 cpu_rdata", 32'(obs_crd[t0+3]), 0);

        // Interleaved traffic with write/read hazards; requests held until accepted.
        vn = 0; cn = 0;
        for (int k = 0; k < 80; k++) begin
            if (m_vg) vn++;
            if (!vid_req || m_vg) begin
                vid_req  = (vn < 24) && (k % 4 != 3);
                vid_addr = 16'(16'h0200 + (vn * 5) % 12);
            end
            if (m_cg) cn++;
            if (!cpu_req || m_cg) begin
                cpu_req   = (cn < 16) && (k % 3 != 2);
                cpu_we    = (cn % 3 == 1);
                cpu_addr  = 16'(16'h0200 + (cn * 7) % 12);
                cpu_wdata = 8'(8'h40 + cn);
            end
            tick();
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
